mem_access_unit: RTL

- Load/store alignment and sub-word access unit between the EX/MEM pipeline register and the word-wide DataMemory; drives DataMemory's Address/WriteData/MemWrite/MemRead and consumes its ReadData.
- Adds byte/halfword loads (sign/zero-extended) and stores, done as read-modify-write.
- Stalls the pipeline for the RMW cycle, registers load results toward MEM/WB and flags illegal accesses.

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store alignment and sub-word access unit in front of a word-wide DataMemory.
// Optional MEM_ACCESS_ALIGN_CHECK_EN: flag misaligned accesses instead of forcing alignment.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MemRead_In,
  input  logic                  MemWrite_In,
  input  logic [1:0]            Size,
  input  logic                  LoadUnsigned,
  input  logic [ADDR_WIDTH-1:0] Address_In,
  input  logic [31:0]           WriteData_In,
  output logic                  Stall,
  output logic [31:0]           LoadData,
  output logic                  LoadValid,
  output logic                  AccessErr,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [31:0]           Mem_WriteData,
  output logic                  Mem_MemWrite,
  output logic                  Mem_MemRead,
  input  logic [31:0]           Mem_ReadData
);

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_BYTES);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, word_addr;
  logic [31:0]           wdata_q, merge_q;
  logic [31:0]           load_ext, merged;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic [1:0]            off;
  logic                  req, illegal;
  logic                  ld_go, rmw_go, err_go;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic                  misalign;
`endif

  assign req       = MemRead_In | MemWrite_In;
  assign word_addr = {Address_In[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    off = Address_In[1:0];
    illegal = (Size == 2'b11)
            | (MemRead_In & MemWrite_In)
            | (Address_In >= LIMIT);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misalign = 1'b0;
    if (Size == 2'b01) misalign = Address_In[0];
    if (Size == 2'b10) misalign = |Address_In[1:0];
    illegal = illegal | misalign;
`else
    if (Size == 2'b01) off[0] = 1'b0;
    if (Size == 2'b10) off = 2'b00;
`endif
  end

  // Big-endian lanes: offset 0 is the most significant byte
  always_comb begin
    bsel   = Mem_ReadData[7:0];
    merged = Mem_ReadData;
    case (off)
      2'd0: begin
        bsel = Mem_ReadData[31:24];
        if (Size == 2'b00) merged[31:24] = WriteData_In[7:0];
      end
      2'd1: begin
        bsel = Mem_ReadData[23:16];
        if (Size == 2'b00) merged[23:16] = WriteData_In[7:0];
      end
      2'd2: begin
        bsel = Mem_ReadData[15:8];
        if (Size == 2'b00) merged[15:8] = WriteData_In[7:0];
      end
      default: begin
        bsel = Mem_ReadData[7:0];
        if (Size == 2'b00) merged[7:0] = WriteData_In[7:0];
      end
    endcase
    hsel = off[1] ? Mem_ReadData[15:0] : Mem_ReadData[31:16];
    if (Size == 2'b01) begin
      if (off[1]) merged[15:0] = WriteData_In[15:0];
      else        merged[31:16] = WriteData_In[15:0];
    end
    case (Size)
      2'b00:   load_ext = {{24{~LoadUnsigned & bsel[7]}}, bsel};
      2'b01:   load_ext = {{16{~LoadUnsigned & hsel[15]}}, hsel};
      default: load_ext = Mem_ReadData;
    endcase
  end

  // Control path kept free of Mem_ReadData so the memory read is not a loop
  always_comb begin
    state_nxt     = state;
    Stall         = 1'b0;
    Mem_MemRead   = 1'b0;
    Mem_MemWrite  = 1'b0;
    Mem_Address   = addr_q;
    Mem_WriteData = wdata_q;
    ld_go         = 1'b0;
    rmw_go        = 1'b0;
    err_go        = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (req && illegal) begin
            err_go = 1'b1;
          end else if (req) begin
            Mem_Address = word_addr;
            if (MemRead_In) begin
              Mem_MemRead = 1'b1;
              ld_go       = 1'b1;
            end else if (Size == 2'b10) begin
              Mem_MemWrite  = 1'b1;
              Mem_WriteData = WriteData_In;
            end else begin
              Mem_MemRead = 1'b1;
              Stall       = 1'b1;
              rmw_go      = 1'b1;
              state_nxt   = RMW_WRITE;
            end
          end
        end
        RMW_WRITE: begin
          Mem_MemWrite  = 1'b1;
          Mem_WriteData = merge_q;
          state_nxt     = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      LoadData  <= '0;
      LoadValid <= 1'b0;
      AccessErr <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_q    <= Mem_Address;
      wdata_q   <= Mem_WriteData;
      LoadValid <= ld_go;
      AccessErr <= err_go;
      if (ld_go)  LoadData <= load_ext;
      if (rmw_go) merge_q  <= merged;
    end
  end

endmodule
